instr_decode_stage_rv: RTL
==========================

// Module: instr_decode_stage_rv
// PURPOSE
//  Registered RV32/RV64 decode stage between fetch and register read. Splits the instruction
//  into fields, classifies format, builds the sign-extended immediate for every format,
//  flags illegal encodings and register usage. Valid/ready handshake on both sides.
//  A 2-entry skid buffer gives full throughput with a registered owReady.
// PARAMETERS
//  XLEN      32  immediate and PC width; 32 or 64. Immediates sign-extend to XLEN.
//  PC_WIDTH  32  width of the pass-through PC tag.
// PORTS
//  iwClk        in   1         clock, rising edge
//  iwRst        in   1         asynchronous reset, active-high
//  iwFlush      in   1         sync flush: drop all held and incoming entries
//  iwValid      in   1         upstream offers iwInstr/iwPc
//  owReady      out  1         stage accepts input this cycle
//  iwInstr      in   32        instruction word
//  iwPc         in   PC_WIDTH  PC of iwInstr
//  owValid      out  1         decoded outputs valid
//  iwReady      in   1         downstream accepts outputs
//  owPc         out  PC_WIDTH  PC of decoded instruction
//  owOpCode     out  7         instr[6:0]
//  owRd         out  5         instr[11:7]
//  owFunct3     out  3         instr[14:12]
//  owRs1        out  5         instr[19:15]
//  owRs2        out  5         instr[24:20]
//  owFunct7     out  7         instr[31:25]
//  owFormat     out  3         0=R 1=I 2=S 3=B 4=U 5=J 7=none
//  owImm        out  XLEN      sign-extended immediate (0 for R/none)
//  owRs1En      out  1         rs1 read (R,I,S,B)
//  owRs2En      out  1         rs2 read (R,S,B)
//  owRdEn       out  1         rd written (R,I,U,J) and owRd != 0
//  owIllegal    out  1         illegal encoding
// BEHAVIOUR
//  Reset: owValid=0, owReady=1, all data outputs 0; both buffer entries empty.
//  Accept: iwValid && owReady at a rising edge. Latency 1: accepted word on outputs next cycle.
//  Output entry M (drives outputs), skid entry S. owReady = !S.valid (registered, no comb path
//  from iwReady). Per edge, fire_out = owValid && iwReady:
//   - M empty or fire_out: M <= S if S.valid (S emptied), else M <= input if accepted.
//     Accepted input while S.valid and fire_out goes to S (S refilled; owReady stays 0).
//   - M full, !fire_out: accepted input -> S.
//  Order strictly preserved; no entry lost or duplicated. owValid/outputs hold stable while
//  owValid && !iwReady.
//  Decode is done on entry to M or S; stored entries hold decoded fields, not raw words.
//  Format by opcode: 0110011,0111011 R; 0010011,0011011,0000011,1100111,1110011,0001111 I;
//   0100011 S; 1100011 B; 0110111,0010111 U; 1101111 J; anything else none.
//  0011011/0111011 (W ops) are format none when XLEN=32.
//  Immediates (then sign-extend instr[31] to XLEN):
//   I {i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],i[11:8],1'b0};
//   U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],1'b0}.
//  owIllegal=1 when: i[1:0]!=2'b11; format none; R-type funct7 not 0000000/0100000/0000001;
//   funct7=0100000 with funct3 not 000/101; iwInstr==32'h0 or 32'hFFFF_FFFF.
//   Illegal entries still flow through normally; format none gives owImm=0 and all En flags 0.
//  Flush: at the edge with iwFlush=1, M and S cleared (owValid=0 next cycle, owReady=1);
//   same-cycle input is dropped even if iwValid && owReady. Flush beats fire_out.
//  Async reset mid-stream: all entries dropped immediately; no output pulse on release.
// TESTING
//  1 iwInstr=32'h00500093 (addi x1,x0,5), iwReady=1 -> next cycle owValid=1, owFormat=1,
//    owImm=5, owRd=1, owRdEn=1, owRs1En=1, owRs2En=0, owIllegal=0.
//  2 Immediates: FE000EE3 (beq, B) -> owImm=-4; FFF00093 -> owImm=-1 (XLEN=64: all ones);
//    800000B7 (lui) -> XLEN=64 owImm=64'hFFFFFFFF80000000; 0000006F (jal x0,0) -> owImm=0,
//    owRdEn=0.
//  3 Backpressure: stream 4 words, hold iwReady=0 two cycles -> owReady drops 1 cycle after
//    S fills; on release all 4 emerge in order, one per cycle, none lost or duplicated.
//  4 Illegal: 32'h0, 32'hFFFFFFFF, 32'h40001033 (funct7=0100000, funct3=001) -> owIllegal=1;
//    32'h40000033 (sub) -> owIllegal=0.
//  5 Flush with M and S full plus iwValid=1 -> next cycle owValid=0, owReady=1, flushed and
//    same-cycle words never appear; async iwRst pulse mid-stream -> same empty state.

Source files
------------

// File: rtl/instr_decode_stage_rv_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and register read.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface instr_decode_stage_rv_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    // Upstream (fetch) side
    logic                iwFlush;
    logic                iwValid;
    logic                owReady;
    logic [31:0]         iwInstr;
    logic [PC_WIDTH-1:0] iwPc;

    // Downstream (register read) side
    logic                owValid;
    logic                iwReady;
    logic [PC_WIDTH-1:0] owPc;
    logic [6:0]          owOpCode;
    logic [4:0]          owRd;
    logic [2:0]          owFunct3;
    logic [4:0]          owRs1;
    logic [4:0]          owRs2;
    logic [6:0]          owFunct7;
    logic [2:0]          owFormat;
    logic [XLEN-1:0]     owImm;
    logic                owRs1En;
    logic                owRs2En;
    logic                owRdEn;
    logic                owIllegal;

    modport slave (
        input  iwFlush, iwValid, iwInstr, iwPc, iwReady,
        output owReady, owValid, owPc, owOpCode, owRd, owFunct3, owRs1, owRs2,
               owFunct7, owFormat, owImm, owRs1En, owRs2En, owRdEn, owIllegal
    );

    modport master (
        output iwFlush, iwValid, iwInstr, iwPc, iwReady,
        input  owReady, owValid, owPc, owOpCode, owRd, owFunct3, owRs1, owRs2,
               owFunct7, owFormat, owImm, owRs1En, owRs2En, owRdEn, owIllegal
    );
endinterface

// File: rtl/instr_decode_stage_rv.sv
// Registered RV32/RV64 decode stage. Instructions are decoded as they are captured, so
// both the output entry (M) and the skid entry (S) hold decoded fields. The skid entry
// lets owReady be a plain register (!S.valid) while still sustaining one word per cycle.
module instr_decode_stage_rv #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                     iwClk,
    input  logic                     iwRst,
    instr_decode_stage_rv_if.slave   bus
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        fmt_e                fmt;
        logic [XLEN-1:0]     imm;
        logic                rs1_en;
        logic                rs2_en;
        logic                rd_en;
        logic                illegal;
    } entry_t;

    // Full decode of one instruction word into a storable entry.
    function automatic entry_t decode(input logic [31:0] instr, input logic [PC_WIDTH-1:0] pc);
        entry_t             e;
        logic signed [31:0] imm32;
        logic               bad_funct;

        e.pc     = pc;
        e.opcode = instr[6:0];
        e.rd     = instr[11:7];
        e.funct3 = instr[14:12];
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        e.funct7 = instr[31:25];

        case (instr[6:0])
            7'b0110011:                         e.fmt = FMT_R;
            7'b0111011:                         e.fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
            7'b0011011:                         e.fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:             e.fmt = FMT_I;
            7'b0100011:                         e.fmt = FMT_S;
            7'b1100011:                         e.fmt = FMT_B;
            7'b0110111, 7'b0010111:             e.fmt = FMT_U;
            7'b1101111:                         e.fmt = FMT_J;
            default:                            e.fmt = FMT_NONE;
        endcase

        // Build a 32-bit signed immediate; the sized cast below sign-extends it to XLEN.
        case (e.fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        e.imm = XLEN'(imm32);

        e.rs1_en = (e.fmt == FMT_R) || (e.fmt == FMT_I) || (e.fmt == FMT_S) || (e.fmt == FMT_B);
        e.rs2_en = (e.fmt == FMT_R) || (e.fmt == FMT_S) || (e.fmt == FMT_B);
        e.rd_en  = ((e.fmt == FMT_R) || (e.fmt == FMT_I) || (e.fmt == FMT_U) || (e.fmt == FMT_J))
                   && (instr[11:7] != 5'd0);

        // funct7 checks apply only to register-register ops; alt encoding only for sub/sra.
        bad_funct = (e.fmt == FMT_R) &&
                    (((instr[31:25] != 7'b0000000) && (instr[31:25] != 7'b0100000) &&
                      (instr[31:25] != 7'b0000001)) ||
                     ((instr[31:25] == 7'b0100000) && (instr[14:12] != 3'b000) &&
                      (instr[14:12] != 3'b101)));

        e.illegal = (instr[1:0] != 2'b11) || (e.fmt == FMT_NONE) || bad_funct ||
                    (instr == 32'h0000_0000) || (instr == 32'hFFFF_FFFF);
        return e;
    endfunction

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   m_valid_q, m_valid_d;
    logic   s_valid_q, s_valid_d;
    entry_t in_entry;
    logic   accept;
    logic   fire_out;

    assign in_entry = decode(bus.iwInstr, bus.iwPc);
    assign accept   = bus.iwValid && !s_valid_q;
    assign fire_out = m_valid_q && bus.iwReady;

    // Next-state for the output and skid entries; flush has priority over everything.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (bus.iwFlush) begin
            m_d       = '0;
            s_d       = '0;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || fire_out) begin
            if (s_valid_q) begin
                // owReady is low while S holds data, so no input can arrive this cycle.
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_d = in_entry;
                end
            end
        end else if (accept) begin
            s_d       = in_entry;
            s_valid_d = 1'b1;
        end
    end

    // Entry registers with asynchronous reset to the empty, all-zero state.
    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign bus.owReady   = !s_valid_q;
    assign bus.owValid   = m_valid_q;
    assign bus.owPc      = m_q.pc;
    assign bus.owOpCode  = m_q.opcode;
    assign bus.owRd      = m_q.rd;
    assign bus.owFunct3  = m_q.funct3;
    assign bus.owRs1     = m_q.rs1;
    assign bus.owRs2     = m_q.rs2;
    assign bus.owFunct7  = m_q.funct7;
    assign bus.owFormat  = m_q.fmt;
    assign bus.owImm     = m_q.imm;
    assign bus.owRs1En   = m_q.rs1_en;
    assign bus.owRs2En   = m_q.rs2_en;
    assign bus.owRdEn    = m_q.rd_en;
    assign bus.owIllegal = m_q.illegal;

endmodule
